req_arbiter4: RTL
=================

REQ_ARBITER4 -- requirements
Module: req_arbiter4

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin selection, 0 = fixed priority (req[3] highest, req[0] lowest).
REQ-002 Parameter MAX_HOLD, default 8: maximum grant cycles while another request is pending; legal range 1..255.
REQ-003 clk  input  1  rising-edge clock; all state changes on this edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low, sampled at rising clk.
REQ-005 req  input  4  request lines; req[i] is requester i.
REQ-006 done  input  1  current owner finished; releases the grant.
REQ-007 gnt  output  4  registered grant, one-hot or all zero.
REQ-008 gnt_id  output  2  registered binary index of the owner; 0 when busy=0.
REQ-009 busy  output  1  registered; 1 when gnt is nonzero.
REQ-010 timeout  output  1  registered one-cycle pulse marking a forced release.

Function
REQ-011 FSM has two states: IDLE (gnt=0) and OWN (exactly one gnt bit set).
REQ-012 IDLE with req=0: stay in IDLE, outputs 0.
REQ-013 IDLE with req!=0 at an edge: pick a winner and enter OWN at that edge; gnt, gnt_id and busy are valid the following cycle (one-cycle latency).
REQ-014 Fixed mode picks the highest set index of req.
REQ-015 RR mode search order is (last-1), (last-2), (last-3), last, all mod 4, where last is the index of the most recent owner; last resets to 0, so the first order is 3,2,1,0.
REQ-016 last updates to the winner index on IDLE->OWN.
REQ-017 hold counter: 8-bit; cleared on IDLE->OWN; increments each OWN cycle; saturates at MAX_HOLD-1.
REQ-018 OWN->IDLE occurs at an edge where done=1, or req[owner]=0, or (counter==MAX_HOLD-1 and (req & ~gnt)!=0).
REQ-019 An owner with no competing request keeps the grant indefinitely; the saturated counter alone does not release it.
REQ-020 Every release is followed by exactly one IDLE cycle with gnt=0 before the next grant; no back-to-back grants.
REQ-021 timeout=1 in the first IDLE cycle after a release caused only by the counter condition; otherwise 0.
REQ-022 done=1 coincident with the timeout condition is a normal release (timeout=0).
REQ-023 done in IDLE is ignored; requests that are not the owner are ignored during OWN.
REQ-024 With MAX_HOLD=1, the owner is released after 1 OWN cycle whenever another request is pending.
REQ-025 gnt_id always equals the encoded gnt; gnt is never multi-hot.

Reset
REQ-026 At an edge with rst_n=0: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, counter=0, last=0; req and done are ignored at that edge.
REQ-027 Reset during OWN drops the grant in the next cycle with no timeout pulse; arbitration resumes at the first edge with rst_n=1.

Verification
REQ-028 Fixed mode, req=4'b0110 held, done pulsed after 3 OWN cycles -> gnt=4'b0100 (id 2) for 3 cycles, then 1 idle cycle, then gnt=4'b0100 again.
REQ-029 RR mode, req=4'b1111 held, done pulsed every 2nd OWN cycle -> owners in order 3,2,1,0,3 with one idle cycle between grants.
REQ-030 MAX_HOLD=4, req=4'b1001 held, no done -> owner 3 for 4 cycles, then timeout=1 with gnt=0, then owner 0 (RR mode).
REQ-031 Single requester req=4'b0010, no done, 20 cycles -> gnt=4'b0010 continuously, timeout never asserted.
REQ-032 rst_n=0 for one edge while owning -> next cycle gnt=0, busy=0, gnt_id=0, timeout=0; with req=4'b1111 after reset, the first RR winner is 3.
REQ-033 done=1 and timeout condition on the same edge -> release with timeout=0; done in IDLE -> no effect.

Source files
------------

// File: rtl/req_arbiter4.sv
// Four-requester arbiter with fixed or round-robin selection and a hold limit.
// A grant is dropped when the owner finishes or leaves, or when it holds too long while others wait.
module req_arbiter4 #(
    parameter int unsigned RR_EN    = 1,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned N  = 4;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      last;

    logic [1:0]      win_id_c;
    logic [1:0]      idx_c;
    logic            owner_req_c;
    logic            others_c;
    logic            hold_hit_c;
    logic            release_c;

    // Winner select; later loop iterations override, so the first-priority candidate is visited last.
    always_comb begin
        win_id_c = '0;
        idx_c    = '0;
        if (RR_EN != 0) begin
            for (int k = N; k >= 1; k--) begin
                idx_c = last - 2'(k);
                if (req[idx_c]) begin
                    win_id_c = idx_c;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    win_id_c = 2'(i);
                end
            end
        end
    end

    always_comb begin
        owner_req_c = req[gnt_id];
        others_c    = |(req & ~gnt);
        hold_hit_c  = (cnt == HOLD_LAST) && others_c;
        release_c   = done || !owner_req_c || hold_hit_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
            last    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        state  <= OWN;
                        gnt    <= 4'b0001 << win_id_c;
                        gnt_id <= win_id_c;
                        busy   <= 1'b1;
                        last   <= win_id_c;
                        cnt    <= '0;
                    end
                end
                OWN: begin
                    if (release_c) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        busy    <= 1'b0;
                        // Only a pure hold-limit release is flagged.
                        timeout <= hold_hit_c && !done && owner_req_c;
                    end else if (cnt != HOLD_LAST) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
